// File: rtl/axi_isolate_pkg.sv
// axi_isolate_pkg: shared isolation state type, default payload widths and counter sizing
package axi_isolate_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} iso_state_e;
    localparam int DEF_AW_PLD_W = 64;
    localparam int DEF_AR_PLD_W = 64;
    localparam int DEF_W_PLD_W  = 81;
    localparam int DEF_R_PLD_W  = 72;
    localparam int DEF_B_PLD_W  = 8;
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/axi_isolate_cnt.sv
// axi_isolate_cnt: up/down burst counter saturating at 0 and MAX, with synchronous clear
module axi_isolate_cnt
    import axi_isolate_pkg::*;
#(
    parameter int MAX = 8,
    localparam int W = cnt_width(MAX)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         is_zero,
    output logic         is_max
);
    assign is_zero = cnt == '0;
    assign is_max  = cnt == W'(MAX);
    always_ff @(posedge clk_i)
        cnt <= (rst_i || clr)               ? '0 :
               (inc && !dec && !is_max)    ? cnt + 1'b1 :
               (dec && !inc && !is_zero)   ? cnt - 1'b1 : cnt;
endmodule

// File: rtl/axi_isolate_drain_ctrl.sv
// axi_isolate_drain_ctrl: drain-then-isolate AXI4 gate with outstanding tracking
// Define AXI_ISOLATE_DRAIN_TIMEOUT_EN to force isolation after TIMEOUT_CYCLES in DRAIN.
module axi_isolate_drain_ctrl
    import axi_isolate_pkg::*;
#(
    parameter int AW_PLD_W        = DEF_AW_PLD_W,
    parameter int AR_PLD_W        = DEF_AR_PLD_W,
    parameter int W_PLD_W         = DEF_W_PLD_W,
    parameter int R_PLD_W         = DEF_R_PLD_W,
    parameter int B_PLD_W         = DEF_B_PLD_W,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int CW = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                isolate_req_i,
    output logic                isolated_o,
    output logic                incoming_req_o,
    output logic [CW-1:0]       wr_outstanding_o,
    output logic [CW-1:0]       rd_outstanding_o,
    output logic                timeout_o,
    input  logic                s_aw_valid_i,
    output logic                s_aw_ready_o,
    input  logic [AW_PLD_W-1:0] s_aw_pld_i,
    input  logic                s_ar_valid_i,
    output logic                s_ar_ready_o,
    input  logic [AR_PLD_W-1:0] s_ar_pld_i,
    input  logic                s_w_valid_i,
    output logic                s_w_ready_o,
    input  logic [W_PLD_W-1:0]  s_w_pld_i,
    input  logic                s_w_last_i,
    output logic                s_r_valid_o,
    input  logic                s_r_ready_i,
    output logic [R_PLD_W-1:0]  s_r_pld_o,
    output logic                s_r_last_o,
    output logic                s_b_valid_o,
    input  logic                s_b_ready_i,
    output logic [B_PLD_W-1:0]  s_b_pld_o,
    output logic                m_aw_valid_o,
    input  logic                m_aw_ready_i,
    output logic [AW_PLD_W-1:0] m_aw_pld_o,
    output logic                m_ar_valid_o,
    input  logic                m_ar_ready_i,
    output logic [AR_PLD_W-1:0] m_ar_pld_o,
    output logic                m_w_valid_o,
    input  logic                m_w_ready_i,
    output logic [W_PLD_W-1:0]  m_w_pld_o,
    output logic                m_w_last_o,
    input  logic                m_r_valid_i,
    output logic                m_r_ready_o,
    input  logic [R_PLD_W-1:0]  m_r_pld_i,
    input  logic                m_r_last_i,
    input  logic                m_b_valid_i,
    output logic                m_b_ready_o,
    input  logic [B_PLD_W-1:0]  m_b_pld_i
);
    iso_state_e    state;
    logic          aw_pend, ar_pend, tmo_fire;
    logic          wr_zero, wr_max, rd_zero, rd_max, wo_zero, wo_max;
    logic [CW-1:0] wo_cnt;
    logic          wo_unused;
    logic          run, drain, iso, aw_pass, ar_pass, w_pass;
    logic          aw_hs, ar_hs, w_last_hs, r_last_hs, b_hs, drained;
    assign run   = state == RUN;
    assign drain = state == DRAIN;
    assign iso   = state == ISOLATED;
    // While draining, only an address already presented downstream may finish its handshake
    assign aw_pass = run ? !wr_max : drain && aw_pend;
    assign ar_pass = run ? !rd_max : drain && ar_pend;
    assign w_pass  = run || (drain && (!wo_zero || aw_pend));
    assign m_aw_valid_o = s_aw_valid_i && aw_pass;
    assign s_aw_ready_o = m_aw_ready_i && aw_pass;
    assign m_aw_pld_o   = s_aw_pld_i;
    assign m_ar_valid_o = s_ar_valid_i && ar_pass;
    assign s_ar_ready_o = m_ar_ready_i && ar_pass;
    assign m_ar_pld_o   = s_ar_pld_i;
    assign m_w_valid_o  = s_w_valid_i && w_pass;
    assign s_w_ready_o  = m_w_ready_i && w_pass;
    assign m_w_pld_o    = s_w_pld_i;
    assign m_w_last_o   = s_w_last_i;
    assign s_r_valid_o  = m_r_valid_i && !iso;
    assign m_r_ready_o  = iso || s_r_ready_i;
    assign s_r_pld_o    = m_r_pld_i;
    assign s_r_last_o   = m_r_last_i;
    assign s_b_valid_o  = m_b_valid_i && !iso;
    assign m_b_ready_o  = iso || s_b_ready_i;
    assign s_b_pld_o    = m_b_pld_i;
    assign incoming_req_o = s_aw_valid_i || s_ar_valid_i || s_w_valid_i;
    assign isolated_o     = iso;
    assign aw_hs     = m_aw_valid_o && m_aw_ready_i;
    assign ar_hs     = m_ar_valid_o && m_ar_ready_i;
    assign w_last_hs = m_w_valid_o && m_w_ready_i && s_w_last_i;
    assign r_last_hs = m_r_valid_i && m_r_ready_o && m_r_last_i;
    assign b_hs      = m_b_valid_i && m_b_ready_o;
    assign drained   = wr_zero && rd_zero && wo_zero && !aw_pend && !ar_pend;
    assign wo_unused = ^{wo_cnt, wo_max};
    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_wr_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc(aw_hs), .dec(b_hs), .clr(tmo_fire),
        .cnt(wr_outstanding_o), .is_zero(wr_zero), .is_max(wr_max)
    );
    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_rd_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc(ar_hs), .dec(r_last_hs), .clr(tmo_fire),
        .cnt(rd_outstanding_o), .is_zero(rd_zero), .is_max(rd_max)
    );
    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_wo_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc(aw_hs), .dec(w_last_hs), .clr(tmo_fire),
        .cnt(wo_cnt), .is_zero(wo_zero), .is_max(wo_max)
    );
`ifdef AXI_ISOLATE_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          timeout_q;
    assign tmo_fire  = drain && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign timeout_o = timeout_q;
    always_ff @(posedge clk_i) begin
        tmo_cnt   <= (rst_i || !drain || tmo_fire) ? '0 : tmo_cnt + 1'b1;
        timeout_q <= rst_i ? 1'b0 : timeout_q || tmo_fire;
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= isolate_req_i ? ISOLATED : RUN;
            aw_pend <= 1'b0;
            ar_pend <= 1'b0;
        end else begin
            aw_pend <= !tmo_fire && (aw_pend ? !aw_hs : m_aw_valid_o && !m_aw_ready_i);
            ar_pend <= !tmo_fire && (ar_pend ? !ar_hs : m_ar_valid_o && !m_ar_ready_i);
            case (state)
                RUN:     state <= isolate_req_i ? DRAIN : RUN;
                DRAIN:   state <= (tmo_fire || (isolate_req_i && drained)) ? ISOLATED :
                                  isolate_req_i ? DRAIN : RUN;
                default: state <= isolate_req_i ? ISOLATED : RUN;
            endcase
        end
    end
endmodule
